// File: rtl/rll16_key_loader.sv
// rll16_key_loader: loads a 16-bit logic-locking key from a serial key store.
// The key arrives LSB first as 17 bits: 16 data bits, then one even-parity bit.
// A key is published on key_out only after the parity check passes. Once a key
// is locked in, the block holds it until reset. A parity failure or a stalled
// stream moves the block to ERROR, and a new start retries the load.
module rll16_key_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        key_sdi,
   input  logic        key_sval,
   output logic        key_req,
   output logic [15:0] key_out,
   output logic        key_valid,
   output logic        key_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      LOCKED,
      ERROR
   } state_t;

   // 254 idle cycles are tolerated; the 255th idle cycle in a row is a timeout.
   localparam logic [7:0] TIMEOUT_LAST = 8'd254;
   localparam logic [4:0] LAST_BIT_IDX = 5'd16;

   state_t      state;
   state_t      next_state;
   logic [16:0] shift_reg;
   logic [4:0]  bit_cnt;
   logic [7:0]  timeout_cnt;

   logic accept;
   logic last_bit;
   logic timeout;
   logic parity_ok;
   logic begin_load;

   // key_sval counts only in LOAD. Outside LOAD the serial port is ignored.
   assign accept     = (state == LOAD) && key_sval;
   assign last_bit   = accept && (bit_cnt == LAST_BIT_IDX);
   assign timeout    = (state == LOAD) && !key_sval && (timeout_cnt == TIMEOUT_LAST);
   // With even parity, the XOR of all 17 captured bits is zero.
   assign parity_ok  = ~(^shift_reg);
   // A load begins when LOAD is entered from IDLE or from ERROR (a retry).
   assign begin_load = (state != LOAD) && (next_state == LOAD);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state always uses non-blocking assignments, so every
         // flop samples the values from before the edge.
         state <= next_state;
      end
   end

   // Next-state logic. start is honoured only in IDLE and ERROR, and LOCKED is terminal.
   always_comb begin
      // NOTE: the default comes first so that every path assigns next_state, and no latch is inferred.
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = LOAD;
         LOAD: begin
            if (last_bit)     next_state = CHECK;
            else if (timeout) next_state = ERROR;
         end
         CHECK:   next_state = parity_ok ? LOCKED : ERROR;
         LOCKED:  next_state = LOCKED;
         ERROR:   if (start) next_state = LOAD;
         default: next_state = IDLE;
      endcase
   end

   // Capture datapath: shift register, bit counter and timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg   <= '0;
         bit_cnt     <= '0;
         timeout_cnt <= '0;
      end else if (begin_load) begin
         shift_reg   <= '0;
         bit_cnt     <= '0;
         timeout_cnt <= '0;
      end else if (accept) begin
         // Shift in from the top. After 17 shifts, the first bit sits in bit 0.
         shift_reg   <= {key_sdi, shift_reg[16:1]};
         bit_cnt     <= bit_cnt + 5'd1;
         timeout_cnt <= '0;
      end else if (state == LOAD) begin
         timeout_cnt <= timeout_cnt + 8'd1;
      end
   end

   // Registered outputs, decoded from the next state so that each output
   // is aligned with the state it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_req   <= 1'b0;
         busy      <= 1'b0;
         key_valid <= 1'b0;
         key_err   <= 1'b0;
         key_out   <= '0;
      end else begin
         key_req   <= (next_state == LOAD);
         busy      <= (next_state == LOAD) || (next_state == CHECK);
         key_valid <= (next_state == LOCKED);
         key_err   <= (next_state == ERROR);
         // key_out is loaded only with a checked key, so a partial key never reaches it.
         if ((state == CHECK) && (next_state == LOCKED)) begin
            key_out <= shift_reg[15:0];
         end else if (next_state == ERROR) begin
            key_out <= '0;
         end
      end
   end

endmodule

// File: doc/rll16_key_loader.md
RLL16_KEY_LOADER -- requirements
Module: rll16_key_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, listed first: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-002 The block SHALL have port start, input, 1 bit: single-cycle request to begin a key load.
REQ-003 The block SHALL have port key_sdi, input, 1 bit: serial key data from the key store.
REQ-004 The block SHALL have port key_sval, input, 1 bit: key_sdi is valid this cycle.
REQ-005 The block SHALL have port key_req, output, 1 bit: asks the key store to stream the key.
REQ-006 The block SHALL have port key_out, output, 16 bits: key to the locked netlist; bit i drives keyIn_0_i.
REQ-007 The block SHALL have port key_valid, output, 1 bit: key_out holds a checked key.
REQ-008 The block SHALL have port key_err, output, 1 bit: the last load failed (parity or timeout).
REQ-009 The block SHALL have port busy, output, 1 bit: a load is in progress.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, LOAD, CHECK, LOCKED and ERROR.
REQ-011 IDLE SHALL go to LOAD on start=1: bit counter cleared, timeout counter cleared, key_err cleared.
REQ-012 In LOAD, key_req=1 and busy=1.
REQ-013 In LOAD, each cycle with key_sval=1 SHALL capture key_sdi into a 17-bit internal shift register.
- First captured bit -> key bit 0 (LSB first).
- Bits 0-15 are key data; bit 16 is the even-parity bit over the 16 data bits.
REQ-014 In LOAD, cycles with key_sval=0 SHALL not shift and SHALL increment an 8-bit timeout counter.
REQ-015 The timeout counter SHALL reset to 0 on every accepted bit.
REQ-016 When the 17th bit is accepted, the FSM SHALL go to CHECK on the next cycle; key_req SHALL deassert in that same cycle.
REQ-017 key_sval asserted outside LOAD SHALL be ignored.
REQ-018 If the timeout counter reaches 255 while in LOAD, the FSM SHALL go to ERROR.
REQ-019 CHECK SHALL last exactly one cycle.
- If the XOR of all 17 captured bits is 0: go to LOCKED, load key_out with data bits 15:0, set key_valid=1.
- Otherwise: go to ERROR.
REQ-020 key_out SHALL change only on the CHECK-to-LOCKED transition; partial keys SHALL never appear on key_out.
REQ-021 ERROR SHALL drive key_err=1, key_valid=0, key_out=16'h0000 and busy=0.
REQ-022 ERROR SHALL go to LOAD on start=1, which clears all counters and key_err (retry).
REQ-023 LOCKED SHALL be terminal until reset: start SHALL be ignored, and key_out and key_valid SHALL hold.
REQ-024 start asserted in LOAD or CHECK SHALL be ignored; the load in progress continues.
REQ-025 Latency SHALL be 2 cycles from acceptance of the 17th bit to key_valid=1, with 0 cycles of gaps on key_sval.
REQ-026 busy SHALL be 1 exactly in LOAD and CHECK.

Reset
REQ-027 On rst=1, asynchronously, the block SHALL enter IDLE and set key_out=16'h0000, key_valid=0, key_err=0, key_req=0, busy=0, and clear the shift register and both counters.
REQ-028 rst asserted mid-LOAD or in LOCKED SHALL discard all captured state; a fresh start is required after release.
REQ-029 Outputs SHALL be registered, and SHALL only change on rising clk edges or asynchronous rst assertion.

Verification
REQ-030 Clean load: start, then 17 back-to-back bits for key 16'hA5C3 with parity 0 -> key_req high 17 cycles, key_out=16'hA5C3, key_valid=1 two cycles after the last bit, key_err=0.
REQ-031 Gapped load: same key with key_sval=0 for 254 cycles between bits 7 and 8 -> no timeout, key_out=16'hA5C3, key_valid=1.
REQ-032 Parity error: key 16'h0001 sent with parity bit 0 -> ERROR, key_err=1, key_out=16'h0000, key_valid=0. Then start plus a correct stream (parity 1) -> key_out=16'h0001, key_valid=1, key_err=0.
REQ-033 Timeout: start, 5 bits, then key_sval=0 for 255 cycles -> key_err=1, busy=0, key_req=0.
REQ-034 Lock persistence: after a valid load of 16'h1234, start plus a new stream of 16'hFFFF -> key_out remains 16'h1234 and key_req stays 0.
REQ-035 Reset mid-load: rst pulsed after 9 bits -> all outputs at reset values immediately. A later start plus a full stream of 16'h00FF -> key_out=16'h00FF.
